// File: rtl/pio_serial_pkg.sv
// pio_serial_pkg: shared FSM state, default sizes and counter-width helper for the PIO serial loader
package pio_serial_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
    localparam int DEF_DATA_W = 6;
    localparam int DEF_CLK_DIV = 4;
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pio_serial_loader_tick.sv
// pio_ser_tick: sclk half-period divider (in: clk, reset, en, clr; out: half_tick on the last cycle of each half-period)
module pio_ser_tick
    import pio_serial_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic half_tick
);
    localparam int W = cnt_w(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] divcnt;
    assign half_tick = en && (divcnt == LAST);
    always_ff @(posedge clk or posedge reset)
        if (reset) divcnt <= '0;
        else if (clr || half_tick) divcnt <= '0;
        else if (en) divcnt <= divcnt + 1'b1;
endmodule

// File: rtl/pio_serial_loader.sv
// pio_serial_loader: shifts each new or resent PIO word into a serial-load device, then latches it (in: clk, reset, pio_data, resend; out: sclk, sdata, slatch, busy)
module pio_serial_loader
    import pio_serial_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pio_data,
    input  logic              resend,
    output logic              sclk,
    output logic              sdata,
    output logic              slatch,
    output logic              busy
);
    localparam int BW = cnt_w(DATA_W);
    state_t state;
    logic [DATA_W-1:0] last_sent, shreg, shifted;
    logic [BW-1:0] bitcnt;
    logic pend_resend, half_tick, trigger;
    function automatic logic pick(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction
    assign trigger = (pio_data != last_sent) || resend || pend_resend;
    assign shifted = LSB_FIRST ? shreg >> 1 : shreg << 1;
    pio_ser_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .en       (state != IDLE),
        .clr      (state == IDLE && trigger),
        .half_tick(half_tick)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_sent   <= '0;
            shreg       <= '0;
            bitcnt      <= '0;
            pend_resend <= 1'b0;
            sclk        <= 1'b0;
            sdata       <= 1'b0;
            slatch      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (trigger) begin
                    shreg       <= pio_data;
                    last_sent   <= pio_data;
                    pend_resend <= 1'b0;
                    bitcnt      <= '0;
                    sdata       <= pick(pio_data);
                    busy        <= 1'b1;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (resend) pend_resend <= 1'b1;
                    if (half_tick) begin
                        sclk <= ~sclk;
                        // falling half ends the bit: advance data while sclk goes low
                        if (sclk) begin
                            shreg  <= shifted;
                            sdata  <= pick(shifted);
                            bitcnt <= bitcnt + 1'b1;
                            if (bitcnt == BW'(DATA_W - 1)) begin
                                slatch <= 1'b1;
                                state  <= LATCH;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (resend) pend_resend <= 1'b1;
                    if (half_tick) begin
                        slatch <= 1'b0;
                        busy   <= 1'b0;
                        sdata  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pio_serial_loader.sv
// tb_pio_serial_loader: scoreboard and vector-table bench for pio_serial_loader
module tb_pio_serial_loader;
    logic clk = 1'b0, reset = 1'b1;
    logic [5:0] pio = '0, pio_b = '0;
    logic resend = 1'b0, resend_b = 1'b0;
    logic sclk, sdata, slatch, busy;
    logic sclk_b, sdata_b, slatch_b, busy_b;
    int checks = 0, errors = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    pio_serial_loader dut (
        .clk(clk), .reset(reset), .pio_data(pio), .resend(resend),
        .sclk(sclk), .sdata(sdata), .slatch(slatch), .busy(busy)
    );

    pio_serial_loader #(.DATA_W(6), .CLK_DIV(1), .LSB_FIRST(1'b1)) dut_b (
        .clk(clk), .reset(reset), .pio_data(pio_b), .resend(resend_b),
        .sclk(sclk_b), .sdata(sdata_b), .slatch(slatch_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_busy(input logic lvl, input int lim);
        int n = 0;
        while (busy !== lvl && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(lvl ? "busy_rise" : "busy_fall", {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    // monitor: rebuilds each shifted word and scores it at the end of the latch pulse
    initial begin
        logic [5:0] word_a, e;
        int nb, blen, slen;
        logic p_sclk, p_sdata, p_slatch, p_busy;
        word_a = '0; nb = 0; blen = 0; slen = 0;
        p_sclk = 0; p_sdata = 0; p_slatch = 0; p_busy = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                word_a = '0; nb = 0; blen = 0; slen = 0;
            end else begin
                if (busy && !p_busy) check("xfer_expected", {31'd0, exp_q.size() != 0}, 1);
                if (busy) blen++;
                if (!busy && p_busy) begin
                    check("busy_len", blen, 52);
                    blen = 0;
                end
                if (sclk) check("sdata_stable", {31'd0, sdata}, {31'd0, p_sdata});
                if (sclk && !p_sclk) begin
                    word_a = {word_a[4:0], sdata};
                    nb++;
                end
                if (slatch) slen++;
                if (!slatch && p_slatch) begin
                    check("latch_len", slen, 4);
                    check("bit_count", nb, 6);
                    if (exp_q.size() == 0) check("latch_expected", 0, 1);
                    else begin
                        e = exp_q.pop_front();
                        check("word", {26'd0, word_a}, {26'd0, e});
                    end
                    word_a = '0; nb = 0; slen = 0;
                end
            end
            p_sclk = sclk; p_sdata = sdata; p_slatch = slatch; p_busy = busy;
        end
    end

    typedef struct {
        logic [5:0] data;
        logic       rs;
        logic       xfer;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int bad, gap, n, blen, nr, tog, sl;
        logic prev;
        logic [5:0] wb;
        tbl[0] = '{6'b101101, 1'b0, 1'b1};
        tbl[1] = '{6'b101101, 1'b0, 1'b0};
        tbl[2] = '{6'b101101, 1'b1, 1'b1};
        tbl[3] = '{6'h00,     1'b1, 1'b1};
        tbl[4] = '{6'h3F,     1'b0, 1'b1};
        tbl[5] = '{6'h01,     1'b0, 1'b1};
        tbl[6] = '{6'h20,     1'b0, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, sclk, sdata, slatch, busy}, 0);
        reset = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({sclk, sdata, slatch, busy} != 4'b0) bad++;
        end
        check("idle_quiet", bad, 0);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (tbl[i].xfer) exp_q.push_back(tbl[i].data);
            pio = tbl[i].data;
            resend = tbl[i].rs;
            @(negedge clk);
            resend = 1'b0;
            if (tbl[i].xfer) begin
                wait_busy(1'b1, 5);
                wait_busy(1'b0, 70);
            end else begin
                bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (busy) bad++;
                end
                check("no_xfer", bad, 0);
            end
            settle();
        end

        exp_q.push_back(6'h15);
        pio = 6'h15;
        wait_busy(1'b1, 5);
        repeat (18) @(negedge clk);
        pio = 6'h2A;
        n = 0;
        while (!slatch && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("reach_latch", {31'd0, slatch}, 1);
        exp_q.push_back(6'h3F);
        pio = 6'h3F;
        wait_busy(1'b0, 10);
        wait_busy(1'b1, 5);
        wait_busy(1'b0, 70);
        settle();

        exp_q.push_back(6'h0C);
        pio = 6'h0C;
        wait_busy(1'b1, 5);
        wait_busy(1'b0, 70);
        settle();
        @(negedge clk);
        exp_q.push_back(6'h0C);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        wait_busy(1'b1, 5);
        repeat (10) @(negedge clk);
        exp_q.push_back(6'h0C);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        wait_busy(1'b0, 70);
        gap = 0;
        while (!busy && gap < 10) begin
            @(negedge clk);
            gap++;
        end
        check("resend_gap", gap, 1);
        wait_busy(1'b0, 70);
        settle();

        exp_q.push_back(6'h33);
        pio = 6'h33;
        wait_busy(1'b1, 5);
        repeat (34) @(negedge clk);
        check("mid_shift_busy", {31'd0, busy}, 1);
        #2 reset = 1'b1;
        #1 check("async_reset", {28'd0, sclk, sdata, slatch, busy}, 0);
        exp_q.delete();
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if ({sclk, sdata, slatch, busy} != 4'b0) bad++;
        end
        check("reset_hold", bad, 0);
        exp_q.push_back(6'h33);
        reset = 1'b0;
        wait_busy(1'b1, 5);
        wait_busy(1'b0, 70);
        settle();
        check("queue_drained", exp_q.size(), 0);

        @(negedge clk);
        pio_b = 6'b000001;
        n = 0;
        while (!busy_b && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("sweep_start", {31'd0, busy_b}, 1);
        blen = 0; nr = 0; tog = 0; sl = 0; prev = 1'b0; wb = '0;
        while (busy_b && blen < 40) begin
            blen++;
            if (sclk_b && !prev) begin
                if (nr < 6) wb[nr] = sdata_b;
                nr++;
            end
            if (sclk_b != prev) tog++;
            if (slatch_b) sl++;
            prev = sclk_b;
            @(negedge clk);
        end
        check("sweep_busy_len", blen, 13);
        check("sweep_bits", nr, 6);
        check("sweep_word", {26'd0, wb}, 32'h01);
        check("sweep_toggles", tog, 12);
        check("sweep_latch", sl, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
